// File: rtl/darkmm_pkg.sv
// Shared types and constants for the darkmm region router.
package darkmm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } mm_state_t;

    localparam logic [1:0] MM_ERR_NONE  = 2'd0;
    localparam logic [1:0] MM_ERR_UNMAP = 2'd1;
    localparam logic [1:0] MM_ERR_TMO   = 2'd2;
    localparam logic [1:0] MM_ERR_RW    = 2'd3;

    localparam int MM_MAX_REGIONS = 8;

endpackage

// File: rtl/darkmm_decode.sv
// Combinational address decode: one-hot region hit (lowest index wins on
// overlap) and the address as seen by the selected device.
module darkmm_decode #(
    parameter int                     NREG    = 3,
    parameter logic [NREG-1:0][31:0]  BASE    = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
    parameter logic [NREG-1:0][7:0]   LOG2SZ  = {8'd30, 8'd29, 8'd29},
    parameter bit                     RELADDR = 1'b1
) (
    input  logic [31:0]     addr_i,
    output logic [NREG-1:0] hit_o,
    output logic [31:0]     dev_addr_o
);

    logic [NREG-1:0]        raw_hit;
    logic [NREG-1:0][31:0]  offset;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_region
            assign raw_hit[gi] = ((addr_i ^ BASE[gi]) >> LOG2SZ[gi]) == 32'd0;
            assign offset[gi]  = RELADDR ? (addr_i - BASE[gi]) : addr_i;
        end
    endgenerate

    // Isolate the lowest set bit so overlapping windows resolve to the lower index.
    assign hit_o = raw_hit & (~raw_hit + NREG'(1));

    always_comb begin
        dev_addr_o = '0;
        for (int i = 0; i < NREG; i++) begin
            if (hit_o[i]) begin
                dev_addr_o = dev_addr_o | offset[i];
            end
        end
    end

endmodule

// File: rtl/darkmm_router.sv
// Registered core-to-device router: decodes one core bus onto NREG device
// ports, bounds each access with a watchdog and logs the first error.
module darkmm_router
    import darkmm_pkg::*;
#(
    parameter int                     NREG    = 3,
    parameter logic [NREG-1:0][31:0]  BASE    = {32'h4000_0000, 32'h2000_0000, 32'h0000_0000},
    parameter logic [NREG-1:0][7:0]   LOG2SZ  = {8'd30, 8'd29, 8'd29},
    parameter bit                     RELADDR = 1'b1,
    parameter int                     TMO     = 255
) (
    input  logic                   XCLK,
    input  logic                   XRES,

    input  logic                   CORE_EN,
    input  logic                   CORE_RE,
    input  logic                   CORE_WE,
    input  logic [3:0]             CORE_BE,
    input  logic [31:0]            CORE_ADDR,
    inout  wire  [31:0]            CORE_DATA,
    output logic                   CORE_RACK,
    output logic                   CORE_WACK,

    output logic [NREG-1:0]        DEV_EN,
    output logic [NREG-1:0]        DEV_RE,
    output logic [NREG-1:0]        DEV_WE,
    output logic [NREG-1:0][3:0]   DEV_BE,
    output logic [NREG-1:0][31:0]  DEV_ADDR,
    inout  wire  [NREG-1:0][31:0]  DEV_DATA,
    input  logic [NREG-1:0]        DEV_RACK,
    input  logic [NREG-1:0]        DEV_WACK,

    output logic                   ERR_VLD,
    output logic [1:0]             ERR_CODE,
    output logic [31:0]            ERR_ADDR,
    input  logic                   ERR_CLR
);

    mm_state_t        state_q, state_d;
    logic [NREG-1:0]  sel_q, sel_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      dev_addr_q, dev_addr_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [31:0]      rdata_q, rdata_d;
    logic [3:0]       be_q, be_d;
    logic             we_q, we_d;
    logic [15:0]      cnt_q, cnt_d;
    logic             err_vld_q, err_vld_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [31:0]      err_addr_q, err_addr_d;

    logic [NREG-1:0]  hit;
    logic [31:0]      hit_addr;
    logic             miss;
    logic             req;
    logic             in_access;
    logic             dev_ack;
    logic [31:0]      dev_rdata;
    logic             err_new;
    logic [1:0]       err_new_code;
    logic [31:0]      err_new_addr;

    darkmm_decode #(
        .NREG    (NREG),
        .BASE    (BASE),
        .LOG2SZ  (LOG2SZ),
        .RELADDR (RELADDR)
    ) u_decode (
        .addr_i     (CORE_ADDR),
        .hit_o      (hit),
        .dev_addr_o (hit_addr)
    );

    assign miss      = ~|hit;
    assign req       = CORE_EN && (CORE_RE || CORE_WE);
    assign in_access = (state_q == ACCESS);
    // Only the ack kind matching the latched op on the selected port counts.
    assign dev_ack   = we_q ? |(DEV_WACK & sel_q) : |(DEV_RACK & sel_q);

    always_comb begin
        dev_rdata = '0;
        for (int i = 0; i < NREG; i++) begin
            if (sel_q[i]) begin
                dev_rdata = dev_rdata | DEV_DATA[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        addr_d       = addr_q;
        dev_addr_d   = dev_addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        be_d         = be_q;
        we_d         = we_q;
        cnt_d        = cnt_q;
        err_new      = 1'b0;
        err_new_code = MM_ERR_NONE;
        err_new_addr = CORE_ADDR;

        case (state_q)
            IDLE: begin
                if (req) begin
                    addr_d     = CORE_ADDR;
                    dev_addr_d = hit_addr;
                    be_d       = CORE_BE;
                    we_d       = CORE_WE;
                    wdata_d    = CORE_DATA;
                    sel_d      = hit;
                    cnt_d      = '0;
                    if (miss) begin
                        state_d      = RESP;
                        rdata_d      = '0;
                        err_new      = 1'b1;
                        err_new_code = MM_ERR_UNMAP;
                    end else begin
                        state_d = ACCESS;
                        if (CORE_RE && CORE_WE) begin
                            err_new      = 1'b1;
                            err_new_code = MM_ERR_RW;
                        end
                    end
                end
            end
            ACCESS: begin
                if (dev_ack) begin
                    if (!we_q) begin
                        rdata_d = dev_rdata;
                    end
                    state_d = RESP;
                end else if (cnt_q == 16'(TMO)) begin
                    rdata_d      = '0;
                    state_d      = RESP;
                    err_new      = 1'b1;
                    err_new_code = MM_ERR_TMO;
                    err_new_addr = addr_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_vld_d  = err_vld_q;
        err_code_d = err_code_q;
        err_addr_d = err_addr_q;
        // A clear coinciding with a fresh error keeps the fresh error.
        if (err_new && (!err_vld_q || ERR_CLR)) begin
            err_vld_d  = 1'b1;
            err_code_d = err_new_code;
            err_addr_d = err_new_addr;
        end else if (ERR_CLR) begin
            err_vld_d  = 1'b0;
            err_code_d = MM_ERR_NONE;
            err_addr_d = '0;
        end
    end

    always_ff @(posedge XCLK or negedge XRES) begin
        if (!XRES) begin
            state_q    <= IDLE;
            sel_q      <= '0;
            addr_q     <= '0;
            dev_addr_q <= '0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            be_q       <= '0;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            err_vld_q  <= 1'b0;
            err_code_q <= MM_ERR_NONE;
            err_addr_q <= '0;
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            addr_q     <= addr_d;
            dev_addr_q <= dev_addr_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            be_q       <= be_d;
            we_q       <= we_d;
            cnt_q      <= cnt_d;
            err_vld_q  <= err_vld_d;
            err_code_q <= err_code_d;
            err_addr_q <= err_addr_d;
        end
    end

    assign CORE_RACK = (state_q == RESP) && !we_q;
    assign CORE_WACK = (state_q == RESP) &&  we_q;
    // With RE and WE both set the core is driving write data, so stay off the bus.
    assign CORE_DATA = (CORE_RE && !CORE_WE) ? rdata_q : 'z;

    genvar gi;
    generate
        for (gi = 0; gi < NREG; gi++) begin : g_dev
            assign DEV_EN[gi]   = in_access && sel_q[gi];
            assign DEV_RE[gi]   = DEV_EN[gi] && !we_q;
            assign DEV_WE[gi]   = DEV_EN[gi] &&  we_q;
            assign DEV_BE[gi]   = DEV_EN[gi] ? be_q : 4'd0;
            assign DEV_ADDR[gi] = DEV_EN[gi] ? dev_addr_q : 32'd0;
            assign DEV_DATA[gi] = (DEV_EN[gi] && we_q) ? wdata_q : 'z;
        end
    endgenerate

    assign ERR_VLD  = err_vld_q;
    assign ERR_CODE = err_code_q;
    assign ERR_ADDR = err_addr_q;

endmodule

// File: doc/darkmm_router.md
# darkmm_router

Parametrised successor to the fixed three-region memory map. Decodes a single core-side `device_bus` into `NREG` device ports with configurable base/size windows. Unlike the combinational map, it registers each transaction through a small FSM, so the decode is outside the device's critical path. It also bounds every access with a timeout watchdog and reports unmapped or hung accesses through a sticky error register. It sits between the core's memory port and the on-chip ROM, flash and external RAM bridges.

## Interface
Parameters:
- `NREG`, 3: number of device regions (1..8).
- `BASE`, {32'h0000_0000, 32'h2000_0000, 32'h4000_0000}: per-region base address; must be aligned to its size.
- `LOG2SZ`, {29, 29, 30}: per-region window size as log2 bytes.
- `RELADDR`, 1: 1 = device sees `ADDR - BASE[i]`; 0 = absolute address.
- `TMO`, 255: maximum cycles spent in ACCESS before abort (1..65535).

Ports:
- `XCLK`  in  1: clock.
- `XRES`  in  1: asynchronous, active-low reset.
- `CORE`  device_bus.cons: core side. Signals are EN, RE, WE, BE[3:0], ADDR[31:0], DATA[31:0] (tristate), RACK, WACK.
- `DEV[NREG]`  device_bus array: device side, same signal set.
- `ERR_VLD`  out  1: sticky error flag.
- `ERR_CODE`  out  2: 1 = unmapped, 2 = timeout, 3 = RE and WE both asserted.
- `ERR_ADDR`  out  32: core address of the first error since the last clear.
- `ERR_CLR`  in  1: clears `ERR_VLD`, `ERR_CODE` and `ERR_ADDR`.

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE:
  - A request is `CORE.EN && (CORE.RE || CORE.WE)`. On a request, latch ADDR, BE, op, write data and the one-hot region hit.
  - Region i hits when `ADDR[31:LOG2SZ[i]] == BASE[i][31:LOG2SZ[i]]`. If windows overlap, the lowest index wins.
  - If RE and WE are both set, the access is performed as a write and code 3 is logged.
  - A hit moves to ACCESS. A miss moves directly to RESP with read data 0 and code 1 logged.
- ACCESS:
  - Drive `DEV[sel]` EN/RE/WE/BE/ADDR from the latched values. All other DEV ports are EN=0, RE=0, WE=0.
  - Wait for `DEV[sel].RACK` (read) or `WACK` (write). On the ack, capture read data and move to RESP.
  - The timeout counter starts at 0 on entry and increments each cycle. If it reaches `TMO` before an ack, move to RESP with read data 0 and log code 2.
- RESP:
  - For one cycle, assert `CORE.RACK` or `CORE.WACK` according to the latched op. Then return to IDLE.
  - Errored accesses are still acknowledged, so the core never hangs.
- Data buses:
  - `CORE.DATA` carries the registered read data while `CORE.RE`, otherwise it is Z.
  - `DEV[sel].DATA` carries the latched write data while in ACCESS with WE set, otherwise it is Z.
- Error register:
  - Only the first error is recorded until it is cleared.
  - If `ERR_CLR` and a new error occur in the same cycle, the new error is recorded.

## Timing
- Reset: state IDLE; all DEV EN/RE/WE = 0; CORE RACK/WACK = 0; read data register 0; ERR_* = 0; timeout counter 0.
- Reset mid-transaction aborts it immediately; no ack is issued.
- Mapped access with the device acking in its first ACCESS cycle: request seen at cycle 0 (IDLE), ACCESS at cycle 1, core ack at cycle 2. Core-to-ack latency is therefore 2 + (device wait cycles).
- Unmapped access: ack at cycle 1.
- Timeout: ack at cycle `TMO` + 2.
- The core holds EN, RE/WE, ADDR, BE and DATA stable until it sees the ack, then deasserts EN.
  - Latched values are used throughout the transaction, so later changes to core inputs are ignored.
  - A request still present in the IDLE cycle after RESP is treated as a new transaction.
- Device acks on unselected ports, and acks outside ACCESS, are ignored.

## Structure
- Package `darkmm_pkg`: state enum `mm_state_t` {IDLE, ACCESS, RESP}; error code constants `MM_ERR_NONE/UNMAP/TMO/RW`; region count limit.
- One sub-module, `darkmm_decode`: a purely combinational address to one-hot region hit plus relative-address computation, parametrised by BASE/LOG2SZ/RELADDR. The FSM, watchdog and error register stay in the top.

## Test plan
- Read 32'h0000_0010; ROM acks after 0 wait cycles with 32'h1234_5678 → `CORE.RACK` at cycle 2, `CORE.DATA` = 32'h1234_5678.
- Write 32'h4000_0100, BE = 4'b0011; RAM acks after 3 wait cycles → `DEV[2]` sees ADDR 32'h0000_0100 and BE 4'b0011; `CORE.WACK` at cycle 5; DEV[0] and DEV[1] EN stay 0.
- Region with no device ack, `TMO` = 8 → `CORE.RACK` at cycle 10, data 0, `ERR_CODE` = 2, `ERR_ADDR` = request address.
- Unmapped access with NREG = 2 (BASE {0, 32'h2000_0000}, LOG2SZ {29, 29}), read 32'h8000_0000 → ack at cycle 1, `ERR_CODE` = 1. A second error does not overwrite it. Asserting `ERR_CLR` in the same cycle as a timeout error → `ERR_CODE` = 2.
- Assert `XRES` low while in ACCESS → all outputs return to their reset values asynchronously; after release, a new read completes normally.
